// File: rtl/hs_unit_reset_seq.sv
// rtl/hs_unit_reset_seq.sv - staged reset sequencer: hold, then release outputs one by one from bit 0
// Optional reset-cause capture enabled by defining HS_RESET_SEQ_CAUSE_EN.
module hs_unit_reset_seq #(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  sw_rst_req,
    input  logic                  ext_rst_req,
`ifdef HS_RESET_SEQ_CAUSE_EN
    input  logic                  cause_clr,
    output logic [2:0]            rst_cause,
`endif
    output logic [NUM_STAGES-1:0] rst_out_n,
    output logic                  busy
);

    if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_num_stages
        $error("hs_unit_reset_seq: NUM_STAGES must be in 1..8");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
        $error("hs_unit_reset_seq: HOLD_CYCLES must be >= 1");
    end
    if (STAGE_GAP < 1) begin : g_bad_stage_gap
        $error("hs_unit_reset_seq: STAGE_GAP must be >= 1");
    end

    localparam int MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    logic [NUM_STAGES-1:0]   rst_d;
    logic                    busy_d;
    logic                    req;

    assign req = sw_rst_req | ext_rst_req;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q   <= ST_ASSERT;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_n <= '0;
            busy      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_n <= rst_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_out_n;
        busy_d  = busy;

        case (state_q)
            ST_ASSERT: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (cnt_q == GAP_LAST) begin
                    // Shifting a one in from bit 0 keeps the outputs thermometer-coded.
                    rst_d = NUM_STAGES'({rst_out_n, 1'b1});
                    cnt_d = '0;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
                idx_d   = '0;
                rst_d   = '0;
                busy_d  = 1'b1;
            end
        endcase

        // A request overrides everything, including the final stage release.
        if (req) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '0;
            busy_d  = 1'b1;
        end
    end

`ifdef HS_RESET_SEQ_CAUSE_EN
    logic [2:0] cause_d;

    always_comb begin
        cause_d = cause_clr ? 3'b000 : rst_cause;
        if (sw_rst_req) begin
            cause_d[1] = 1'b1;
        end
        if (ext_rst_req) begin
            cause_d[2] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rst_cause <= 3'b001;
        end else begin
            rst_cause <= cause_d;
        end
    end
`endif

endmodule

// File: tb/tb_hs_unit_reset_seq.sv
// tb/tb_hs_unit_reset_seq.sv - directed self-checking bench for hs_unit_reset_seq (default parameters)
module tb_hs_unit_reset_seq;

    logic       clk;
    logic       areset;
    logic       sw_rst_req;
    logic       ext_rst_req;
    logic [2:0] rst_out_n;
    logic       busy;
`ifdef HS_RESET_SEQ_CAUSE_EN
    logic       cause_clr;
    logic [2:0] rst_cause;
`endif

    int n_cmp;
    int n_bad;

    hs_unit_reset_seq #(
        .NUM_STAGES (3),
        .HOLD_CYCLES(16),
        .STAGE_GAP  (4)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .sw_rst_req (sw_rst_req),
        .ext_rst_req(ext_rst_req),
`ifdef HS_RESET_SEQ_CAUSE_EN
        .cause_clr  (cause_clr),
        .rst_cause  (rst_cause),
`endif
        .rst_out_n  (rst_out_n),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-derived release pattern: edge j after the last request/reset release.
    function automatic logic [2:0] therm(input int j);
        logic [2:0] v;
        v[0] = (j >= 20);
        v[1] = (j >= 24);
        v[2] = (j >= 28);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        areset      = 1'b1;
        sw_rst_req  = 1'b0;
        ext_rst_req = 1'b0;
`ifdef HS_RESET_SEQ_CAUSE_EN
        cause_clr   = 1'b0;
`endif
        repeat (3) tick();
        n_cmp++;
        if (rst_out_n !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_rst_out_n: got %b expected %b", rst_out_n, 3'b000);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_busy: got %b expected %b", busy, 1'b1);
        end
        areset = 1'b0;
    endtask

    task automatic test_power_up();
        for (int j = 1; j <= 28; j++) begin
            tick();
            n_cmp++;
            if (rst_out_n !== therm(j)) begin
                n_bad++;
                $display("FAIL power_up_rst edge %0d: got %b expected %b", j, rst_out_n, therm(j));
            end
            n_cmp++;
            if (busy !== (j < 28)) begin
                n_bad++;
                $display("FAIL power_up_busy edge %0d: got %b expected %b", j, busy, (j < 28));
            end
        end
    endtask

    task automatic test_sw_pulse();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        n_cmp++;
        if (rst_out_n !== 3'b000 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL sw_pulse_assert: got rst=%b busy=%b expected rst=000 busy=1", rst_out_n, busy);
        end
        for (int j = 1; j <= 28; j++) begin
            tick();
            n_cmp++;
            if (rst_out_n !== therm(j) || busy !== (j < 28)) begin
                n_bad++;
                $display("FAIL sw_pulse_release edge %0d: got rst=%b busy=%b expected rst=%b busy=%b",
                         j, rst_out_n, busy, therm(j), (j < 28));
            end
        end
    endtask

    task automatic test_ext_hold();
        ext_rst_req = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            n_cmp++;
            if (rst_out_n !== 3'b000 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL ext_hold cycle %0d: got rst=%b busy=%b expected rst=000 busy=1",
                         i, rst_out_n, busy);
            end
        end
        ext_rst_req = 1'b0;
        for (int j = 1; j <= 28; j++) begin
            tick();
            n_cmp++;
            if (rst_out_n !== therm(j)) begin
                n_bad++;
                $display("FAIL ext_hold_release edge %0d: got %b expected %b", j, rst_out_n, therm(j));
            end
        end
    endtask

    task automatic test_last_stage_collision();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        for (int j = 1; j <= 27; j++) begin
            tick();
        end
        n_cmp++;
        if (rst_out_n !== 3'b011) begin
            n_bad++;
            $display("FAIL collision_pre: got %b expected %b", rst_out_n, 3'b011);
        end
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        n_cmp++;
        if (rst_out_n !== 3'b000 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL collision_priority: got rst=%b busy=%b expected rst=000 busy=1", rst_out_n, busy);
        end
        // Re-entering the hold phase is shown by the full 20-edge hold before stage 0.
        for (int j = 1; j <= 28; j++) begin
            tick();
            n_cmp++;
            if (rst_out_n !== therm(j) || busy !== (j < 28)) begin
                n_bad++;
                $display("FAIL collision_release edge %0d: got rst=%b busy=%b expected rst=%b busy=%b",
                         j, rst_out_n, busy, therm(j), (j < 28));
            end
        end
    endtask

    task automatic test_async_reset();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        for (int j = 1; j <= 24; j++) begin
            tick();
        end
        n_cmp++;
        if (rst_out_n !== 3'b011) begin
            n_bad++;
            $display("FAIL async_pre: got %b expected %b", rst_out_n, 3'b011);
        end
        #2;
        areset = 1'b1;
        #1;
        n_cmp++;
        if (rst_out_n !== 3'b000 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL async_immediate: got rst=%b busy=%b expected rst=000 busy=1", rst_out_n, busy);
        end
        #2;
        areset = 1'b0;
        for (int j = 1; j <= 28; j++) begin
            tick();
            n_cmp++;
            if (rst_out_n !== therm(j) || busy !== (j < 28)) begin
                n_bad++;
                $display("FAIL async_release edge %0d: got rst=%b busy=%b expected rst=%b busy=%b",
                         j, rst_out_n, busy, therm(j), (j < 28));
            end
        end
    endtask

`ifdef HS_RESET_SEQ_CAUSE_EN
    task automatic test_cause();
        n_cmp++;
        if (rst_cause !== 3'b001) begin
            n_bad++;
            $display("FAIL cause_power_on: got %b expected %b", rst_cause, 3'b001);
        end
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
        n_cmp++;
        if (rst_cause !== 3'b000) begin
            n_bad++;
            $display("FAIL cause_clear: got %b expected %b", rst_cause, 3'b000);
        end
        sw_rst_req = 1'b1;
        cause_clr  = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        cause_clr  = 1'b0;
        n_cmp++;
        if (rst_cause !== 3'b010) begin
            n_bad++;
            $display("FAIL cause_sw_with_clear: got %b expected %b", rst_cause, 3'b010);
        end
        ext_rst_req = 1'b1;
        tick();
        ext_rst_req = 1'b0;
        n_cmp++;
        if (rst_cause !== 3'b110) begin
            n_bad++;
            $display("FAIL cause_ext_sticky: got %b expected %b", rst_cause, 3'b110);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_power_up();
        test_sw_pulse();
        test_ext_hold();
        test_last_stage_collision();
        test_async_reset();
`ifdef HS_RESET_SEQ_CAUSE_EN
        test_cause();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hs_unit_reset_seq.md
HS_UNIT_RESET_SEQ -- requirements
Module: hs_unit_reset_seq

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 3: number of sequenced reset outputs, legal range 1..8.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 16: cycles all outputs stay asserted before release begins, legal range >= 1.
REQ-003 The block SHALL have parameter STAGE_GAP, default 4: cycles between successive stage releases, legal range >= 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port areset, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port sw_rst_req, input, 1 bit: synchronous software reset request, sampled each cycle.
REQ-007 The block SHALL have port ext_rst_req, input, 1 bit: synchronous external or watchdog reset request, sampled each cycle.
REQ-008 The block SHALL have port rst_out_n, output, NUM_STAGES bits: active-low sequenced resets; bit 0 is released first.
REQ-009 The block SHALL have port busy, output, 1 bit: high while any rst_out_n bit is low.
REQ-010 Elaboration SHALL fail on any illegal parameter value.

Function
REQ-011 The block SHALL implement FSM states ASSERT, RELEASE and RUN, a cycle counter sized for max(HOLD_CYCLES, STAGE_GAP), and a stage index sized for NUM_STAGES.
REQ-012 ASSERT: the counter SHALL increment each cycle; when the counter equals HOLD_CYCLES-1, the FSM SHALL enter RELEASE with counter=0 and index=0.
REQ-013 RELEASE: when the counter equals STAGE_GAP-1, the block SHALL set rst_out_n[index]=1, clear the counter and increment index; releasing the last stage SHALL enter RUN.
REQ-014 Latency: after areset deasserts with no requests, rst_out_n[k] SHALL go high at rising edge HOLD_CYCLES+(k+1)*STAGE_GAP (defaults: edges 20, 24, 28); busy SHALL fall on the same edge as the last stage.
REQ-015 Released bits SHALL stay high until the next reassertion, so rst_out_n is thermometer-coded from bit 0 at all times.
REQ-016 req = sw_rst_req OR ext_rst_req, sampled in any state, SHALL register the next state to ASSERT with counter=0, all rst_out_n=0 and busy=1 on that edge.
REQ-017 In ASSERT, a request SHALL restart the hold count, so a held request keeps the outputs asserted indefinitely.
REQ-018 A request in the same cycle as the last stage release SHALL take priority: the FSM enters ASSERT, not RUN.
REQ-019 All outputs SHALL be registered with no combinational path from the request inputs to the outputs.

Reset
REQ-020 While areset is high, the block SHALL asynchronously force state=ASSERT, counter=0, index=0, rst_out_n=all zeros and busy=1.
REQ-021 areset asserted mid-sequence or in RUN SHALL immediately drive all rst_out_n low, independent of clk.
REQ-022 On areset deassertion, sequencing SHALL begin from the first following rising edge per REQ-014.

Configuration
REQ-023 With macro HS_RESET_SEQ_CAUSE_EN defined, the block SHALL add input cause_clr (1 bit) and output rst_cause (3 bits): [0] power-on, [1] software, [2] external.
REQ-024 With HS_RESET_SEQ_CAUSE_EN, areset SHALL set rst_cause to 3'b001.
REQ-025 With HS_RESET_SEQ_CAUSE_EN, sw_rst_req SHALL set rst_cause[1] and ext_rst_req SHALL set rst_cause[2] (sticky OR), and cause_clr SHALL clear all bits.
REQ-026 With HS_RESET_SEQ_CAUSE_EN, a request in the same cycle as cause_clr SHALL win: the block clears the other bits and sets the requested bit.
REQ-027 Without HS_RESET_SEQ_CAUSE_EN, cause_clr, rst_cause and all related logic SHALL be absent and sequencing behaviour SHALL be identical.

Verification
REQ-028 The bench SHALL cover: defaults, release areset, no requests -> rst_out_n 000->001 at edge 20, 011 at 24, 111 at 28, busy low at 28.
REQ-029 The bench SHALL cover: sw_rst_req pulse for 1 cycle in RUN -> rst_out_n=000 on the next edge, then release repeats at +20/+24/+28 edges.
REQ-030 The bench SHALL cover: ext_rst_req held for 50 cycles -> outputs stay 000 throughout, and stage 0 releases 20 edges after the last sampled request.
REQ-031 The bench SHALL cover: request on the edge where stage 2 would release -> rst_out_n=000, busy stays 1, and the FSM is in ASSERT.
REQ-032 The bench SHALL cover: areset pulse between clk edges while rst_out_n=011 -> rst_out_n=000 immediately, without waiting for a clock edge.
REQ-033 The bench SHALL cover, with HS_RESET_SEQ_CAUSE_EN: power-on -> rst_cause=001; then cause_clr -> 000; then sw_rst_req and cause_clr together -> 010; then ext_rst_req -> 110.
